// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants and state encoding for the IMem boot loader
package imem_loader_pkg;
    localparam int XLEN           = 32;
    localparam int IMEM_DEPTH     = 256;
    localparam int AW             = $clog2(IMEM_DEPTH);
    localparam int LEN_W          = AW + 1;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_CHKRX,
        ST_CMP,
        ST_DONE,
        ST_ERROR
    } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, IMem write port and core control bundle of the loader
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic             Start;        // single-cycle load request
    logic [LEN_W-1:0] Len_Words;    // payload length, sampled on accepted Start
    logic [7:0]       Byte_In;      // stream byte
    logic             Byte_Valid;   // Byte_In is valid
    logic             Byte_Ready;   // loader accepts Byte_In this cycle
    logic             IMem_Wr_En;   // IMem write strobe
    logic [AW-1:0]    IMem_Wr_Idx;  // IMem word index
    logic [XLEN-1:0]  IMem_Wr_Data; // IMem write word
    logic             EN_PC;        // core run enable
    logic             Busy;         // load in progress
    logic             Done;         // sticky: last load passed
    logic             Err;          // sticky: last load failed

    modport master (
        output Start, Len_Words, Byte_In, Byte_Valid,
        input  Byte_Ready, IMem_Wr_En, IMem_Wr_Idx, IMem_Wr_Data,
        input  EN_PC, Busy, Done, Err
    );

    modport slave (
        input  Start, Len_Words, Byte_In, Byte_Valid,
        output Byte_Ready, IMem_Wr_En, IMem_Wr_Idx, IMem_Wr_Data,
        output EN_PC, Busy, Done, Err
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian byte-to-word packer shared by payload and checksum
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            byte_accept,
    input  logic [7:0]      byte_in,
    output logic [XLEN-1:0] word,
    output logic            word_full
);
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = '0;
        end else if (byte_accept) begin
            word_d[{cnt_q, 3'b000} +: 8] = byte_in;
            // Counter wraps to 0 after the last byte, so no clear is needed between words.
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Pulses on the cycle the last byte of a word is accepted; word holds it from the next cycle.
    assign word_full = byte_accept && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word      = word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time IMem writer with XOR checksum and core run gating
module imem_loader
    import imem_loader_pkg::*;
(
    input logic          CLK,
    input logic          rst,
    imem_loader_if.slave bus
);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(IMEM_DEPTH);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]  chk_q, chk_d;
    logic [AW-1:0]    wr_idx_q, wr_idx_d;
    logic [XLEN-1:0]  wr_data_q, wr_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             en_pc_q, en_pc_d;

    logic             byte_ready;
    logic             byte_accept;
    logic             pk_clear;
    logic [XLEN-1:0]  pk_word;
    logic             pk_full;
    logic             in_write;

    assign byte_ready  = (state_q == ST_RECV) || (state_q == ST_CHKRX);
    assign byte_accept = bus.Byte_Valid && byte_ready;
    assign in_write    = (state_q == ST_WRITE);

    imem_loader_byte_packer u_packer (
        .clk         (CLK),
        .rst         (rst),
        .clear       (pk_clear),
        .byte_accept (byte_accept),
        .byte_in     (bus.Byte_In),
        .word        (pk_word),
        .word_full   (pk_full)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        en_pc_d   = en_pc_q;
        pk_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.Start) begin
                    len_d    = bus.Len_Words;
                    idx_d    = '0;
                    chk_d    = '0;
                    pk_clear = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    en_pc_d  = 1'b0;
                    busy_d   = 1'b1;
                    if (bus.Len_Words > LEN_MAX) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else if (bus.Len_Words == '0) begin
                        state_d = ST_CHKRX;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (pk_full) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                chk_d     = chk_q ^ pk_word;
                idx_d     = idx_q + LEN_W'(1);
                wr_idx_d  = idx_q[AW-1:0];
                wr_data_d = pk_word;
                state_d   = ((idx_q + LEN_W'(1)) == len_q) ? ST_CHKRX : ST_RECV;
            end
            ST_CHKRX: begin
                if (pk_full) state_d = ST_CMP;
            end
            ST_CMP: begin
                busy_d = 1'b0;
                if (pk_word == chk_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    en_pc_d = 1'b1;
                end else begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                    en_pc_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            chk_q     <= '0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            en_pc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            en_pc_q   <= en_pc_d;
        end
    end

    // During WRITE the live index/word are presented; afterwards the captured copy keeps them stable.
    assign bus.Byte_Ready   = byte_ready;
    assign bus.IMem_Wr_En   = in_write;
    assign bus.IMem_Wr_Idx  = in_write ? idx_q[AW-1:0] : wr_idx_q;
    assign bus.IMem_Wr_Data = in_write ? pk_word : wr_data_q;
    assign bus.EN_PC        = en_pc_q;
    assign bus.Busy         = busy_q;
    assign bus.Done         = done_q;
    assign bus.Err          = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic CLK = 1'b0;
    logic rst = 1'b1;

    imem_loader_if ifc();

    imem_loader dut (
        .CLK (CLK),
        .rst (rst),
        .bus (ifc)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:IMEM_DEPTH-1];
    int wr_count      = 0;
    int cyc           = 0;
    int write_accepts = 0;
    int ready_cycles  = 0;

    bit stuck         = 1'b0;
    bit first_pending = 1'b0;
    int first_cyc     = 0;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ifc.IMem_Wr_En) begin
            mem[ifc.IMem_Wr_Idx] <= ifc.IMem_Wr_Data;
            wr_count <= wr_count + 1;
            if (ifc.Byte_Valid && ifc.Byte_Ready) write_accepts <= write_accepts + 1;
        end
        if (ifc.Byte_Ready) ready_cycles <= ready_cycles + 1;
    end

    task automatic start_load(input int len);
        ifc.Start     = 1'b1;
        ifc.Len_Words = LEN_W'(len);
        @(negedge CLK);
        ifc.Start     = 1'b0;
        stuck         = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int t;
        t = 0;
        if (stuck) return;
        ifc.Byte_In    = b;
        ifc.Byte_Valid = 1'b1;
        while (!ifc.Byte_Ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!ifc.Byte_Ready) begin
            n_checks++;
            n_fail++;
            stuck = 1'b1;
            ifc.Byte_Valid = 1'b0;
            $display("FAIL byte_timeout ready=%0b required=1", ifc.Byte_Ready);
            return;
        end
        if (first_pending) begin
            first_cyc     = cyc;
            first_pending = 1'b0;
        end
        @(negedge CLK);
        ifc.Byte_Valid = 1'b0;
        if (gap_max > 0) begin
            repeat ($urandom_range(gap_max, 0)) begin
                ifc.Byte_In = 8'($urandom);
                @(negedge CLK);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
    endtask

    task automatic wait_end(input string tag);
        int t;
        t = 0;
        while (!(ifc.Done || ifc.Err) && t < 400) begin
            @(negedge CLK);
            t++;
        end
        if (!(ifc.Done || ifc.Err)) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_end_timeout done=%0b err=%0b required=one_set", tag, ifc.Done, ifc.Err);
        end
    endtask

    // Reference: payload words land at indices 0..n-1; load passes iff checksum equals XOR of words.
    task automatic do_load(input int n, input int gap_max, input bit corrupt, input string tag);
        logic [31:0] w[$];
        logic [31:0] x;
        logic [31:0] chk;
        int w0;
        int bad;
        x = '0;
        for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            x ^= w[i];
        end
        chk = corrupt ? (x ^ (32'h1 << $urandom_range(31, 0))) : x;
        w0  = wr_count;
        start_load(n);
        n_checks++;
        if (ifc.Busy !== 1'b1 || ifc.EN_PC !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy got busy=%0b en_pc=%0b required busy=1 en_pc=0", tag, ifc.Busy, ifc.EN_PC);
        end
        for (int i = 0; i < n; i++) send_word(w[i], gap_max);
        send_word(chk, gap_max);
        wait_end(tag);
        n_checks++;
        if (ifc.Done !== !corrupt || ifc.Err !== corrupt || ifc.EN_PC !== !corrupt || ifc.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_status got done=%0b err=%0b en_pc=%0b busy=%0b required done=%0b err=%0b en_pc=%0b busy=0",
                     tag, ifc.Done, ifc.Err, ifc.EN_PC, ifc.Busy, !corrupt, corrupt, !corrupt);
        end
        n_checks++;
        if (wr_count - w0 !== n) begin
            n_fail++;
            $display("FAIL %s_write_count got=%0d required=%0d", tag, wr_count - w0, n);
        end
        bad = 0;
        for (int i = 0; i < n; i++) if (mem[i] !== w[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_mem got %0d wrong words required 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({ifc.Byte_Ready, ifc.IMem_Wr_En, ifc.IMem_Wr_Idx, ifc.IMem_Wr_Data,
             ifc.EN_PC, ifc.Busy, ifc.Done, ifc.Err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got ready=%0b we=%0b en_pc=%0b busy=%0b done=%0b err=%0b required all 0",
                     ifc.Byte_Ready, ifc.IMem_Wr_En, ifc.EN_PC, ifc.Busy, ifc.Done, ifc.Err);
        end
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_good_load();
        logic [7:0] seq [12];
        int w0;
        seq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h80, 8'h05, 8'h10, 8'h00};
        w0 = wr_count;
        start_load(2);
        first_pending = 1'b1;
        for (int i = 0; i < 12; i++) send_byte(seq[i], 0);
        wait_end("good");
        n_checks++;
        if (cyc - first_cyc !== 15) begin
            n_fail++;
            $display("FAIL good_latency got=%0d required=15", cyc - first_cyc);
        end
        n_checks++;
        if (mem[0] !== 32'h00000513 || mem[1] !== 32'h00100093 || wr_count - w0 !== 2) begin
            n_fail++;
            $display("FAIL good_mem got idx0=%08h idx1=%08h writes=%0d required 00000513 00100093 2",
                     mem[0], mem[1], wr_count - w0);
        end
        n_checks++;
        if (ifc.Done !== 1'b1 || ifc.EN_PC !== 1'b1 || ifc.Err !== 1'b0 || ifc.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_status got done=%0b en_pc=%0b err=%0b busy=%0b required 1 1 0 0",
                     ifc.Done, ifc.EN_PC, ifc.Err, ifc.Busy);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] seq [8];
        int w0;
        seq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        w0 = wr_count;
        start_load(2);
        for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
        send_word(32'h0, 0);
        wait_end("badchk");
        n_checks++;
        if (ifc.Err !== 1'b1 || ifc.Done !== 1'b0 || ifc.EN_PC !== 1'b0 || wr_count - w0 !== 2) begin
            n_fail++;
            $display("FAIL badchk_status got err=%0b done=%0b en_pc=%0b writes=%0d required 1 0 0 2",
                     ifc.Err, ifc.Done, ifc.EN_PC, wr_count - w0);
        end
    endtask

    task automatic test_len_error();
        int w0;
        int r0;
        w0 = wr_count;
        r0 = ready_cycles;
        start_load(IMEM_DEPTH + 1);
        n_checks++;
        if (ifc.Err !== 1'b1 || ifc.Done !== 1'b0 || ifc.Busy !== 1'b0 || ifc.EN_PC !== 1'b0) begin
            n_fail++;
            $display("FAIL lenerr_status got err=%0b done=%0b busy=%0b en_pc=%0b required 1 0 0 0",
                     ifc.Err, ifc.Done, ifc.Busy, ifc.EN_PC);
        end
        ifc.Byte_Valid = 1'b1;
        repeat (6) @(negedge CLK);
        ifc.Byte_Valid = 1'b0;
        n_checks++;
        if (wr_count != w0 || ready_cycles != r0) begin
            n_fail++;
            $display("FAIL lenerr_activity got writes=%0d ready_cycles=%0d required 0 0",
                     wr_count - w0, ready_cycles - r0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0v;
        logic [31:0] w1v;
        int wa0;
        w0v = $urandom;
        w1v = {24'($urandom), 8'hAB};
        wa0 = write_accepts;
        start_load(2);
        send_byte(w0v[7:0], 0);
        // A Start mid-load must be ignored.
        ifc.Start     = 1'b1;
        ifc.Len_Words = LEN_W'(1);
        @(negedge CLK);
        ifc.Start     = 1'b0;
        for (int k = 1; k < 4; k++) send_byte(w0v[8*k +: 8], 0);
        send_word(w1v, 0);
        send_word(w0v ^ w1v, 0);
        wait_end("bp");
        n_checks++;
        if (mem[0] !== w0v || mem[1] !== w1v || write_accepts != wa0) begin
            n_fail++;
            $display("FAIL bp_mem got idx0=%08h idx1=%08h write_accepts=%0d required %08h %08h 0",
                     mem[0], mem[1], write_accepts - wa0, w0v, w1v);
        end
        n_checks++;
        if (ifc.Done !== 1'b1 || ifc.Err !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_status got done=%0b err=%0b required 1 0", ifc.Done, ifc.Err);
        end
    endtask

    task automatic test_random_loads();
        for (int i = 0; i < 6; i++)
            do_load($urandom_range(8, 1), 3, 1'($urandom_range(1, 0)), "rand");
    endtask

    task automatic test_reset_reload();
        int w0;
        int t;
        w0 = wr_count;
        start_load(3);
        send_word($urandom, 0);
        send_word($urandom, 0);
        t = 0;
        while (wr_count - w0 < 2 && t < 20) begin
            @(negedge CLK);
            t++;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (ifc.EN_PC !== 1'b0 || ifc.Busy !== 1'b0 || ifc.Byte_Ready !== 1'b0 ||
            ifc.IMem_Wr_En !== 1'b0 || ifc.Done !== 1'b0 || ifc.Err !== 1'b0 || wr_count - w0 !== 2) begin
            n_fail++;
            $display("FAIL midrst_outputs got en_pc=%0b busy=%0b ready=%0b we=%0b done=%0b err=%0b writes=%0d required 0s and 2 writes",
                     ifc.EN_PC, ifc.Busy, ifc.Byte_Ready, ifc.IMem_Wr_En, ifc.Done, ifc.Err, wr_count - w0);
        end
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        start_load(1);
        send_word(32'hDEADBEEF, 0);
        send_word(32'hDEADBEEF, 0);
        wait_end("reload");
        n_checks++;
        if (mem[0] !== 32'hDEADBEEF || ifc.Done !== 1'b1 || ifc.EN_PC !== 1'b1) begin
            n_fail++;
            $display("FAIL reload got idx0=%08h done=%0b en_pc=%0b required deadbeef 1 1",
                     mem[0], ifc.Done, ifc.EN_PC);
        end
    endtask

    initial begin
        ifc.Start      = 1'b0;
        ifc.Len_Words  = '0;
        ifc.Byte_In    = '0;
        ifc.Byte_Valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_len_error();
        do_load(0, 0, 1'b0, "len0");
        do_load(0, 0, 1'b1, "len0bad");
        test_backpressure();
        test_random_loads();
        do_load(IMEM_DEPTH, 0, 1'b0, "full");
        test_reset_reload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the core's instruction memory, which the core itself only ever reads.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes the words sequentially into IMem, then checks a trailing XOR checksum word.
- Holds the core's EN_PC low until a load completes with a good checksum.
- Sits between the board-level byte source (UART/JTAG bridge) and the IMem write port / core EN_PC input.

Parameters:
XLEN, 32, instruction/data word width (fixed at 32 for byte packing)
IMEM_DEPTH, 256, number of IMem words
AW, $clog2(IMEM_DEPTH), IMem word-index width

Ports:
CLK  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
Start  input  1  single-cycle load request
Len_Words  input  AW+1  payload length in words; sampled only on an accepted Start
Byte_In  input  8  stream byte
Byte_Valid  input  1  Byte_In is valid
Byte_Ready  output  1  loader accepts Byte_In this cycle
IMem_Wr_En  output  1  IMem write strobe
IMem_Wr_Idx  output  AW  IMem word index
IMem_Wr_Data  output  32  IMem write word
EN_PC  output  1  core run enable
Busy  output  1  load in progress
Done  output  1  sticky: last load passed the checksum
Err  output  1  sticky: last load failed (bad length or checksum)

Behaviour:
- Reset (async, immediate): state IDLE; every output 0, including EN_PC. Internal index, byte count, word register and checksum are all cleared.
- States:
  - IDLE: waiting for Start.
  - RECV: payload bytes.
  - WRITE: one-cycle IMem write.
  - CHKRX: checksum bytes.
  - CMP: checksum compare.
  - DONE: load passed.
  - ERROR: load failed.
- Start is accepted only in IDLE, DONE or ERROR; it is ignored in all other states.
  - On accept: latch Len_Words; clear index, byte count and checksum; clear Done/Err; set Busy=1 and EN_PC=0, registered, so they take effect on the next cycle.
  - Len_Words > IMEM_DEPTH: go to ERROR, Err=1 next cycle, no writes.
  - Len_Words = 0: go straight to CHKRX; the expected checksum is 0.
  - Otherwise: go to RECV.
- Handshake:
  - A byte transfers on a cycle with Byte_Valid & Byte_Ready.
  - Byte_Ready=1 only in RECV and CHKRX.
  - Byte_Valid while not ready has no effect. The source holds the byte until it is accepted.
- Packing: the k-th accepted byte (k = 0..3) goes to word bits [8k+7:8k].
- WRITE, entered the cycle after the 4th payload byte:
  - IMem_Wr_En=1 for exactly one cycle, with IMem_Wr_Idx=index and IMem_Wr_Data=packed word.
  - checksum ^= word; index++.
  - Next state is CHKRX if index has reached Len, else RECV.
- CHKRX collects 4 bytes the same way. CMP is entered the cycle after the 4th checksum byte and lasts one cycle.
  - Received word == running XOR: go to DONE. Done=1, EN_PC=1, Busy=0.
  - Mismatch: go to ERROR. Err=1, EN_PC=0, Busy=0. Words already written remain in IMem.
- IMem_Wr_Idx/IMem_Wr_Data hold their last values outside WRITE. IMem_Wr_En=0 outside WRITE.
- Timing with Byte_Valid held high: N words take 5N + 5 cycles from the first accepted byte to Done.
- Index never wraps, because Len is bounded by IMEM_DEPTH. Len = IMEM_DEPTH writes indices 0..IMEM_DEPTH-1.
- rst mid-load: immediate return to IDLE with EN_PC=0. Partial IMem contents are left as they are. A subsequent Start performs a full reload.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, RECV, WRITE, CHKRX, CMP, DONE, ERROR);
  - the BYTES_PER_WORD=4 constant;
  - IMEM_DEPTH, shared with IMem.
- One sub-module, byte_packer:
  - 2-bit byte counter plus 32-bit shift/insert register;
  - word_full pulse; clear input.
  - Instantiated once and shared by the payload and checksum phases.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 immediately; state IDLE; Byte_Ready=0.
- Good load: Start with Len=2; bytes 13 05 00 00 93 00 10 00 80 05 10 00 → writes idx0=0x00000513 and idx1=0x00100093, one Wr_En cycle each; Done=1, EN_PC=1, Err=0, Busy=0.
- Bad checksum: same payload, checksum bytes 00 00 00 00 → both writes occur; Err=1, Done=0, EN_PC stays 0.
- Length error: IMEM_DEPTH=256, Start with Len=257 → Err=1 next cycle; no Wr_En; Byte_Ready never 1.
- Backpressure: Byte_Valid held high through the WRITE cycle with next byte 0xAB → 0xAB not consumed during WRITE; accepted the following cycle as bits [7:0] of word 1. Random Valid gaps give identical IMem contents.
- Reset mid-load then reload: rst after word 1 written → EN_PC=0, IDLE. Start with Len=1, word 0xDEADBEEF, checksum 0xDEADBEEF → idx0 overwritten; Done=1.
